// File: rtl/vernam_pkg.sv
// Shared types and defaults for the Vernam one-time-pad stream engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vernam_pkg;

  localparam int VERNAM_DATA_W = 8;

  // Controller FSM encoding
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/vernam_key_store.sv
// Circular key store: write port, read-and-advance port, count/full flags.
// Latency: writes visible to the read port one cycle later; rd_data is combinational.
// Backpressure: none internally; callers must qualify wr_en with !full and rd_en with count>0.
// Build option: VERNAM_KEY_ZEROIZE_EN wipes consumed entries and the whole array on flush.
module vernam_key_store import vernam_pkg::*; #(
  parameter int DATA_W    = VERNAM_DATA_W,
  parameter int KEY_DEPTH = 16,
  parameter int CNT_W     = $clog2(KEY_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic [CNT_W-1:0]  count_nxt,
  output logic              full
);

  localparam int PTR_W = $clog2(KEY_DEPTH);

  logic [DATA_W-1:0] mem [KEY_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Next occupancy; a simultaneous write and consume leaves it unchanged
  always_comb begin
    count_nxt = count;
    if (flush) count_nxt = '0;
    else       count_nxt = count + CNT_W'(wr_en) - CNT_W'(rd_en);
  end

  assign full    = (count == CNT_W'(KEY_DEPTH));
  assign rd_data = mem[rd_ptr];

  // Pointers and count; pointers wrap naturally since KEY_DEPTH is a power of 2
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
        if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Key array; wr_ptr and rd_ptr only coincide when empty or full, so the
  // qualified write and the consume-side wipe never target the same entry
  always_ff @(posedge clk) begin
`ifdef VERNAM_KEY_ZEROIZE_EN
    if (flush) begin
      for (int i = 0; i < KEY_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) mem[wr_ptr] <= wr_data;
      if (rd_en) mem[rd_ptr] <= '0;
    end
`else
    if (wr_en) mem[wr_ptr] <= wr_data;
`endif
  end

endmodule

// File: rtl/vernam_otp_controller.sv
// One-time-pad engine: XORs each accepted plaintext byte with the oldest unused key byte.
// Latency: exactly 1 cycle from pt accept to ct_valid; 1 byte/cycle sustained.
// Backpressure: pt_ready drops when the store is empty, halted, or ct is held by !ct_ready.
// Build option: VERNAM_KEY_ZEROIZE_EN (consumed/flushed key entries are wiped).
module vernam_otp_controller import vernam_pkg::*; #(
  parameter int DATA_W    = VERNAM_DATA_W,
  parameter int KEY_DEPTH = 16,
  parameter int CNT_W     = $clog2(KEY_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_flush,
  input  logic              key_wr_en,
  input  logic [DATA_W-1:0] key_wr_data,
  output logic              key_full,
  output logic [CNT_W-1:0]  key_count,
  input  logic              pt_valid,
  input  logic [DATA_W-1:0] pt_data,
  output logic              pt_ready,
  output logic              ct_valid,
  output logic [DATA_W-1:0] ct_data,
  input  logic              ct_ready,
  output logic              key_overflow,
  output logic [15:0]       bytes_done
);

  state_t            state;
  state_t            state_nxt;
  logic              accept;
  logic              wr_ok;
  logic              ovf_evt;
  logic [DATA_W-1:0] key_byte;
  logic [CNT_W-1:0]  count_nxt;

  vernam_key_store #(
    .DATA_W    (DATA_W),
    .KEY_DEPTH (KEY_DEPTH),
    .CNT_W     (CNT_W)
  ) u_key_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (key_flush),
    .wr_en     (wr_ok),
    .wr_data   (key_wr_data),
    .rd_en     (accept),
    .rd_data   (key_byte),
    .count     (key_count),
    .count_nxt (count_nxt),
    .full      (key_full)
  );

  // Handshake decode; flush wins over a same-cycle write or accept
  always_comb begin
    pt_ready = 1'b0;
    accept   = 1'b0;
    wr_ok    = 1'b0;
    ovf_evt  = 1'b0;
    pt_ready = (state == S_RUN) && (!ct_valid || ct_ready);
    accept   = pt_valid && pt_ready && !key_flush;
    wr_ok    = key_wr_en && !key_full && (state != S_HALT) && !key_flush;
    ovf_evt  = key_wr_en && key_full && !key_flush;
  end

  // Next state: overflow halts from anywhere; otherwise track key availability
  always_comb begin
    state_nxt = state;
    if (key_flush) begin
      state_nxt = S_EMPTY;
    end else if (ovf_evt || state == S_HALT) begin
      state_nxt = S_HALT;
    end else begin
      case (state)
        S_EMPTY: state_nxt = (count_nxt != '0) ? S_RUN : S_EMPTY;
        S_RUN:   state_nxt = (count_nxt != '0) ? S_RUN : S_EMPTY;
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_EMPTY;
    else        state <= state_nxt;
  end

  // Halt is only ever reached through an overflow, so it doubles as the sticky flag
  assign key_overflow = (state == S_HALT);

  // Ciphertext output register: loads on accept, holds while stalled, clears after handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ct_valid <= 1'b0;
      ct_data  <= '0;
    end else if (accept) begin
      ct_valid <= 1'b1;
      ct_data  <= pt_data ^ key_byte;
    end else if (ct_valid && ct_ready) begin
      ct_valid <= 1'b0;
    end
  end

  // Delivered-byte counter, wraps at 16 bits
  always_ff @(posedge clk) begin
    if (!rst_n)                  bytes_done <= '0;
    else if (ct_valid && ct_ready) bytes_done <= bytes_done + 16'd1;
  end

endmodule

// File: tb/tb_vernam_otp_controller.sv
// Directed bench for the one-time-pad controller with hand-computed vectors.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
// The store wipe behaviour is checked according to VERNAM_KEY_ZEROIZE_EN.
module tb_vernam_otp_controller;

  logic        clk;
  logic        rst_n;
  logic        key_flush;
  logic        key_wr_en;
  logic [7:0]  key_wr_data;
  logic        key_full;
  logic [4:0]  key_count;
  logic        pt_valid;
  logic [7:0]  pt_data;
  logic        pt_ready;
  logic        ct_valid;
  logic [7:0]  ct_data;
  logic        ct_ready;
  logic        key_overflow;
  logic [15:0] bytes_done;

  int passed = 0;
  int total  = 0;

  vernam_otp_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_flush    (key_flush),
    .key_wr_en    (key_wr_en),
    .key_wr_data  (key_wr_data),
    .key_full     (key_full),
    .key_count    (key_count),
    .pt_valid     (pt_valid),
    .pt_data      (pt_data),
    .pt_ready     (pt_ready),
    .ct_valid     (ct_valid),
    .ct_data      (ct_data),
    .ct_ready     (ct_ready),
    .key_overflow (key_overflow),
    .bytes_done   (bytes_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic write_key(input logic [7:0] d);
    key_wr_en   = 1'b1;
    key_wr_data = d;
    clk1();
    key_wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clk1();
    rst_n = 1'b1;
  endtask

  task automatic do_flush();
    key_flush = 1'b1;
    clk1();
    key_flush = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [7:0] pt_v [4];
  logic [7:0] ct_e [4];

  initial begin
    pt_v = '{8'h41, 8'h4D, 8'h41, 8'h4E};
    ct_e = '{8'h0A, 8'h08, 8'h18, 8'h05};
    rst_n = 1'b0; key_flush = 1'b0; key_wr_en = 1'b0; key_wr_data = 8'h00;
    pt_valid = 1'b0; pt_data = 8'h00; ct_ready = 1'b0;
    clk1(); clk1();

    // Reset state
    check("rst_count", key_count, 0);
    check("rst_full", key_full, 0);
    check("rst_pt_ready", pt_ready, 0);
    check("rst_ct_valid", ct_valid, 0);
    check("rst_ct_data", ct_data, 0);
    check("rst_ovf", key_overflow, 0);
    check("rst_bytes", bytes_done, 0);
    check("rst_state", dut.state, 0);
    rst_n = 1'b1;

    // KEYK xor AMAN, full throughput
    write_key(8'h4B); write_key(8'h45); write_key(8'h59); write_key(8'h4B);
    check("t1_count4", key_count, 4);
    check("t1_state_run", dut.state, 1);
    ct_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pt_valid = 1'b1;
      pt_data  = pt_v[i];
      #1;
      check("t1_pt_ready", pt_ready, 1);
      clk1();
      check("t1_ct_valid", ct_valid, 1);
      check("t1_ct_data", ct_data, ct_e[i]);
      check("t1_count", key_count, 3 - i);
    end
    pt_valid = 1'b0;
    check("t1_state_empty", dut.state, 0);
    clk1();
    check("t1_drained", ct_valid, 0);
    check("t1_bytes", bytes_done, 4);

    // Empty store stalls; key usable the cycle after it is written
    pt_valid = 1'b1; pt_data = 8'h41;
    repeat (4) begin
      clk1();
      check("t2_stall", pt_ready, 0);
    end
    key_wr_en = 1'b1; key_wr_data = 8'h4B;
    #1;
    check("t2_same_cycle", pt_ready, 0);
    clk1();
    key_wr_en = 1'b0;
    #1;
    check("t2_ready_next", pt_ready, 1);
    check("t2_no_ct_yet", ct_valid, 0);
    clk1();
    check("t2_ct_valid", ct_valid, 1);
    check("t2_ct_data", ct_data, 8'h0A);
    pt_valid = 1'b0;
    clk1();
    check("t2_bytes", bytes_done, 5);

    // Output stall holds data and blocks input
    do_reset();
    write_key(8'h4B); write_key(8'h45); write_key(8'h59); write_key(8'h4B);
    ct_ready = 1'b1; pt_valid = 1'b1; pt_data = 8'h41;
    clk1();
    check("t3_first", ct_data, 8'h0A);
    ct_ready = 1'b0; pt_data = 8'h4D;
    for (int i = 0; i < 3; i++) begin
      clk1();
      check("t3_hold_data", ct_data, 8'h0A);
      check("t3_hold_valid", ct_valid, 1);
      check("t3_hold_ready", pt_ready, 0);
      check("t3_hold_count", key_count, 3);
    end
    ct_ready = 1'b1;
    #1;
    check("t3_release_ready", pt_ready, 1);
    for (int i = 1; i < 4; i++) begin
      pt_data = pt_v[i];
      clk1();
      check("t3_ct_data", ct_data, ct_e[i]);
    end
    pt_valid = 1'b0;
    clk1();
    check("t3_drained", ct_valid, 0);
    check("t3_bytes", bytes_done, 4);

    // Overflow halts; flush recovers
    do_reset();
    for (int i = 0; i < 16; i++) write_key(8'(i));
    check("t4_full", key_full, 1);
    check("t4_count16", key_count, 16);
    write_key(8'hAA);
    pt_valid = 1'b1;
    #1;
    check("t4_ovf", key_overflow, 1);
    check("t4_halt", dut.state, 2);
    check("t4_pt_ready", pt_ready, 0);
    check("t4_count_kept", key_count, 16);
    pt_valid = 1'b0;
    do_flush();
    check("t4_flush_ovf", key_overflow, 0);
    check("t4_flush_count", key_count, 0);
    check("t4_flush_state", dut.state, 0);
    check("t4_flush_full", key_full, 0);

    // Full store: simultaneous write and accept still overflows
    for (int i = 0; i < 16; i++) write_key(8'h10 + 8'(i));
    pt_valid = 1'b1; pt_data = 8'h00; ct_ready = 1'b1;
    key_wr_en = 1'b1; key_wr_data = 8'hFF;
    clk1();
    pt_valid = 1'b0; key_wr_en = 1'b0;
    #1;
    check("t5_ovf", key_overflow, 1);
    check("t5_halt", dut.state, 2);
    check("t5_count15", key_count, 15);
    check("t5_ct_data", ct_data, 8'h10);
    check("t5_halt_ready", pt_ready, 0);
    clk1();
    check("t5_halt_drain", ct_valid, 0);
    do_flush();

    // key_count 8: simultaneous write and accept leaves count unchanged
    for (int i = 0; i < 8; i++) write_key(8'h20 + 8'(i));
    check("t5_count8_pre", key_count, 8);
    pt_valid = 1'b1; pt_data = 8'h00;
    key_wr_en = 1'b1; key_wr_data = 8'h99;
    clk1();
    pt_valid = 1'b0; key_wr_en = 1'b0;
    check("t5_count8", key_count, 8);
    check("t5_ct8", ct_data, 8'h20);
    check("t5_no_ovf", key_overflow, 0);
    clk1();

    // Reset mid-stream drops the pending byte
    do_flush();
    write_key(8'h4B);
    pt_valid = 1'b1; pt_data = 8'h41;
    clk1();
    pt_valid = 1'b0; ct_ready = 1'b0;
    check("t6_pending", ct_valid, 1);
    check("t6_bytes_pre", bytes_done, 2);
`ifdef VERNAM_KEY_ZEROIZE_EN
    check("t6_zeroized", dut.u_key_store.mem[0], 8'h00);
`else
    check("t6_stale_kept", dut.u_key_store.mem[0], 8'h4B);
`endif
    do_reset();
    check("t6_ct_valid", ct_valid, 0);
    check("t6_count", key_count, 0);
    check("t6_bytes", bytes_done, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vernam_otp_controller.md
Name: vernam_otp_controller

Overview:
- Sequences the byte-wide Vernam XOR datapath as a one-time-pad stream engine.
- Key bytes are loaded into an internal circular key store. Each plaintext byte accepted on a valid/ready input stream is XORed with the oldest unused key byte, and the result is emitted on a valid/ready output stream.
- Guarantees no key byte is ever used twice. Stalls when the key store is empty and halts on key overflow.
- Sits between the host byte source/sink and the key provisioning path.

Parameters:
- DATA_W, 8, byte width of plaintext, key and ciphertext.
- KEY_DEPTH, 16, number of key entries in the store; must be a power of 2, ≥2.
- CNT_W, $clog2(KEY_DEPTH)+1, width of key_count.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- key_flush  in  1  synchronous clear of the key store and error state.
- key_wr_en  in  1  key byte write strobe.
- key_wr_data  in  DATA_W  key byte.
- key_full  out  1  key store holds KEY_DEPTH unused bytes.
- key_count  out  CNT_W  number of unused key bytes.
- pt_valid  in  1  plaintext byte valid.
- pt_data  in  DATA_W  plaintext byte.
- pt_ready  out  1  controller accepts pt_data this cycle.
- ct_valid  out  1  ciphertext byte valid.
- ct_data  out  DATA_W  ciphertext byte.
- ct_ready  in  1  sink accepts ct_data.
- key_overflow  out  1  sticky error: a write was attempted while the store was full.
- bytes_done  out  16  count of ciphertext bytes accepted by the sink; wraps.

Behaviour:
- Reset (rst_n=0 at clk edge): pointers and key_count=0, key_full=0, pt_ready=0, ct_valid=0, ct_data=0, key_overflow=0, bytes_done=0, FSM=S_EMPTY.
- FSM states:
  - S_EMPTY: key_count==0.
  - S_RUN: key_count>0.
  - S_HALT: entered on any key_wr_en while key_full, from any state. Exited only by key_flush or reset, to S_EMPTY.
- Other transitions: S_EMPTY→S_RUN when key_count becomes >0; S_RUN→S_EMPTY when key_count becomes 0.
- pt_ready = (state==S_RUN) && (!ct_valid || ct_ready). pt_ready is combinational from registered state and ct_ready only; it does not depend on pt_valid.
- Accept (pt_valid && pt_ready):
  - Next cycle, ct_data = pt_data ^ key[rd_ptr] and ct_valid=1.
  - rd_ptr increments mod KEY_DEPTH.
  - Latency is exactly 1 cycle. Full throughput of 1 byte/cycle is sustained while ct_ready=1 and key is available.
- Output holding: ct_data and ct_valid hold stable while ct_valid && !ct_ready. ct_valid clears after the handshake unless a new byte is accepted in the same cycle.
- bytes_done increments on each ct_valid && ct_ready.
- Key write:
  - When key_wr_en && !key_full && state!=S_HALT: key[wr_ptr] = key_wr_data and wr_ptr increments mod KEY_DEPTH.
  - key_wr_en while key_full: data is dropped, key_overflow=1, state→S_HALT.
  - Writes in S_HALT are dropped.
- Simultaneous write and consume in one cycle: key_count is unchanged.
  - When full, a simultaneous consume does not prevent overflow. key_full is evaluated on the pre-cycle count.
  - When key_count==0, a written byte is not consumable in the same cycle. It is usable the next cycle.
- Empty store: pt_ready=0 and the upstream stalls. No error is raised.
- Halt: pt_ready=0. An already-registered ct byte still drains normally.
- key_flush: pointers, key_count and key_overflow are cleared, and state→S_EMPTY. An in-flight ct byte is retained until the handshake. key_flush takes priority over a same-cycle key write or accept; both are ignored.
- Reset mid-stream drops any pending ct byte.
- key_full = (key_count==KEY_DEPTH).

Optional Feature:
- Macro: VERNAM_KEY_ZEROIZE_EN.
- Defined: on each consume, the used key entry is overwritten with 0 in the same cycle. key_flush zeroes all entries over the flush cycle. Consumed key material is not recoverable from the store.
- Undefined: consumed entries retain stale data, and flush clears only pointers and counts.
- Ports and timing are identical in both builds.

Decomposition:
- Shared package vernam_pkg holds:
  - DATA_W default.
  - FSM state encoding localparams: S_EMPTY=2'd0, S_RUN=2'd1, S_HALT=2'd2.
- One natural sub-module, vernam_key_store: circular buffer with write port, read-and-advance port, count/full flags, and zeroize hook.
- The XOR and output register stay in the top module.

Test Plan:
- Load keys 'K','E','Y','K' (0x4B,0x45,0x59,0x4B), then stream 'A','M','A','N' with ct_ready=1 → ct_data 0x0A,0x08,0x18,0x05 on consecutive cycles, each 1 cycle after accept. key_count goes 4→0 and state ends S_EMPTY.
- pt_valid=1 with an empty store → pt_ready=0 indefinitely. Write key 0x4B → pt_ready=1 on the cycle after the write, and 'A' yields 0x0A.
- Load 4 keys and hold ct_ready=0 for 3 cycles while streaming → ct_data stays 0x0A and pt_ready=0 during the stall. Release → 0x08,0x18,0x05 follow and bytes_done=4.
- Fill all 16 entries, then write one more → key_overflow=1, state S_HALT, pt_ready=0. Pulse key_flush → key_overflow=0, key_count=0, state S_EMPTY.
- Store full, with a simultaneous write and accept → overflow flagged. With key_count=8, a simultaneous write and accept → key_count stays 8.
- Assert rst_n=0 while ct_valid=1 → next cycle ct_valid=0, key_count=0, bytes_done=0. With VERNAM_KEY_ZEROIZE_EN, a consumed entry reads back 0 via hierarchical peek.
